// File: rtl/calc_pkg.sv
// calc_pkg: shared status, sequencer state and result constants for the calculator divider path
package calc_pkg;
    typedef enum logic [1:0] {ST_OK, ST_DIV0, ST_OVF, ST_TIMEOUT} status_t;
    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, BLANK, WAIT, RESP} seq_state_t;
    localparam logic [7:0] QUOT_SAT = 8'hFF;
    localparam logic [7:0] REM_ERR  = 8'h00;
endpackage

// File: rtl/div_sequencer.sv
// div_sequencer: request/response front end that screens, launches and times out an unsigned divider
module div_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DONE_BLANK     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 31
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [15:0] ReqDividend,
    input  logic [7:0]  ReqDivisor,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [7:0]  RspQuotient,
    output logic [7:0]  RspRemainder,
    output logic [1:0]  RspStatus,
    output logic        Busy,
    output logic [15:0] DivDividend,
    output logic [7:0]  DivDivisor,
    output logic        DivStart,
    input  logic        DivDone,
    input  logic [7:0]  DivQuotient,
    input  logic [7:0]  DivRemainder
);
    localparam logic [3:0] BLANK_LAST = 4'(DONE_BLANK - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    seq_state_t state;
    logic [3:0] blank_cnt;
    logic [7:0] tmo_cnt;

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            ReqReady     <= 1'b1;
            RspValid     <= 1'b0;
            DivStart     <= 1'b0;
            Busy         <= 1'b0;
            RspQuotient  <= '0;
            RspRemainder <= '0;
            RspStatus    <= '0;
            DivDividend  <= '0;
            DivDivisor   <= '0;
            blank_cnt    <= '0;
            tmo_cnt      <= '0;
        end else begin
            DivStart <= 1'b0;
            unique case (state)
                IDLE: if (ReqValid && ReqReady) begin
                    DivDividend <= ReqDividend;
                    DivDivisor  <= ReqDivisor;
                    ReqReady    <= 1'b0;
                    Busy        <= 1'b1;
                    state       <= CHECK;
                end
                CHECK: if (DivDivisor == 8'd0 || DivDividend[15:8] >= DivDivisor) begin
                    RspStatus    <= (DivDivisor == 8'd0) ? ST_DIV0 : ST_OVF;
                    RspQuotient  <= QUOT_SAT;
                    RspRemainder <= REM_ERR;
                    RspValid     <= 1'b1;
                    state        <= RESP;
                end else begin
                    DivStart <= 1'b1;
                    state    <= LAUNCH;
                end
                LAUNCH: begin
                    blank_cnt <= '0;
                    tmo_cnt   <= '0;
                    state     <= BLANK;
                end
                BLANK: begin
                    blank_cnt <= blank_cnt + 4'd1;
                    tmo_cnt   <= tmo_cnt + 8'd1;
                    if (blank_cnt == BLANK_LAST) state <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (DivDone || tmo_cnt == TMO_LAST) begin
                        RspStatus    <= DivDone ? ST_OK : ST_TIMEOUT;
                        RspQuotient  <= DivDone ? DivQuotient : 8'd0;
                        RspRemainder <= DivDone ? DivRemainder : 8'd0;
                        RspValid     <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: if (RspReady) begin
                    RspValid <= 1'b0;
                    ReqReady <= 1'b1;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against a divider model and stubs
module tb_div_sequencer;
    localparam int DB = 1;
    localparam int T  = 31;

    logic        Clock = 0, Reset = 1;
    logic        ReqValid = 0, RspReady = 0;
    logic [15:0] ReqDividend = 0;
    logic [7:0]  ReqDivisor = 0;
    logic        ReqReady, RspValid, Busy, DivStart, DivDone;
    logic [7:0]  RspQuotient, RspRemainder, DivDivisor, DivQuotient, DivRemainder;
    logic [1:0]  RspStatus;
    logic [15:0] DivDividend;

    int errors = 0, checks = 0;
    int mode = 0;
    int lat_cfg = 4;
    int dcnt = 0;
    int start_cnt = 0;
    logic       real_done = 0;
    logic [7:0] dq = 0, dr = 0;

    div_sequencer #(.DONE_BLANK(DB), .TIMEOUT_CYCLES(T)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqDividend(ReqDividend), .ReqDivisor(ReqDivisor), .RspValid(RspValid),
        .RspReady(RspReady), .RspQuotient(RspQuotient), .RspRemainder(RspRemainder),
        .RspStatus(RspStatus), .Busy(Busy), .DivDividend(DivDividend), .DivDivisor(DivDivisor),
        .DivStart(DivStart), .DivDone(DivDone), .DivQuotient(DivQuotient), .DivRemainder(DivRemainder)
    );

    always #5 Clock = ~Clock;

    // Divider model: mode 0 real divider with lat_cfg latency and sticky Done, 1 Done stuck low, 2 Done stuck high
    always @(posedge Clock) begin
        if (DivStart) begin
            dcnt      <= lat_cfg;
            real_done <= 1'b0;
            start_cnt <= start_cnt + 1;
        end else if (dcnt == 1) begin
            dcnt      <= 0;
            real_done <= 1'b1;
            dq        <= 8'(int'(DivDividend) / int'(DivDivisor));
            dr        <= 8'(int'(DivDividend) % int'(DivDivisor));
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end
    end
    assign DivDone      = (mode == 0) ? real_done : (mode == 2);
    assign DivQuotient  = (mode == 0) ? dq : 8'hA5;
    assign DivRemainder = (mode == 0) ? dr : 8'h5A;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issues one request from IDLE; lat = edge index (acceptance edge = 0) after which RspValid is first seen, -1 if never
    task automatic run_req(input logic [15:0] a, input logic [7:0] b, output int lat);
        ReqDividend = a;
        ReqDivisor  = b;
        ReqValid    = 1;
        @(posedge Clock); #1;
        ReqValid = 0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge Clock); #1;
            if (RspValid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        RspReady = 1;
        @(posedge Clock); #1;
        RspReady = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({ReqReady, RspValid, DivStart, Busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {ReqReady, RspValid, DivStart, Busy});
        end
        checks++;
        if ({RspQuotient, RspRemainder, RspStatus, DivDividend, DivDivisor} !== 42'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {RspQuotient, RspRemainder, RspStatus, DivDividend, DivDivisor});
        end
        Reset = 0;
        @(posedge Clock); #1;
    endtask

    task automatic test_real_divide();
        int lat, s0;
        mode = 0; lat_cfg = 5; s0 = start_cnt;
        run_req(16'd1000, 8'd7, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b00, 8'h8E, 8'h06}) begin
            errors++;
            $display("FAIL real_1000_7: got st=%b q=%h r=%h expected st=00 q=8e r=06", RspStatus, RspQuotient, RspRemainder);
        end
        checks++;
        if (lat !== 3 + 5) begin
            errors++;
            $display("FAIL real_latency: got %0d expected %0d", lat, 3 + 5);
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL real_start_pulses: got %0d expected 1", start_cnt - s0);
        end
        finish_rsp();
    endtask

    task automatic test_div0();
        int lat, s0;
        s0 = start_cnt;
        run_req(16'h1234, 8'h00, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b01, 8'hFF, 8'h00} || lat !== 1) begin
            errors++;
            $display("FAIL div0: got st=%b q=%h r=%h lat=%0d expected st=01 q=ff r=00 lat=1", RspStatus, RspQuotient, RspRemainder, lat);
        end
        checks++;
        if (start_cnt !== s0) begin
            errors++;
            $display("FAIL div0_no_start: got %0d pulses expected 0", start_cnt - s0);
        end
        finish_rsp();
    endtask

    task automatic test_overflow_boundary();
        int lat;
        run_req(16'h0800, 8'h08, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b10, 8'hFF, 8'h00} || lat !== 1) begin
            errors++;
            $display("FAIL ovf_0800_08: got st=%b q=%h r=%h lat=%0d expected st=10 q=ff r=00 lat=1", RspStatus, RspQuotient, RspRemainder, lat);
        end
        finish_rsp();
        mode = 0; lat_cfg = 3;
        run_req(16'h07FF, 8'h08, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b00, 8'hFF, 8'h07} || lat !== 6) begin
            errors++;
            $display("FAIL ok_07ff_08: got st=%b q=%h r=%h lat=%0d expected st=00 q=ff r=07 lat=6", RspStatus, RspQuotient, RspRemainder, lat);
        end
        finish_rsp();
    endtask

    task automatic test_stubs();
        int lat;
        mode = 1;
        run_req(16'd100, 8'd3, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b11, 8'h00, 8'h00} || lat !== 2 + T) begin
            errors++;
            $display("FAIL timeout: got st=%b q=%h r=%h lat=%0d expected st=11 q=00 r=00 lat=%0d", RspStatus, RspQuotient, RspRemainder, lat, 2 + T);
        end
        finish_rsp();
        mode = 2;
        run_req(16'd100, 8'd3, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b00, 8'hA5, 8'h5A} || lat !== 3 + DB) begin
            errors++;
            $display("FAIL done_stuck_high: got st=%b q=%h r=%h lat=%0d expected st=00 q=a5 r=5a lat=%0d", RspStatus, RspQuotient, RspRemainder, lat, 3 + DB);
        end
        finish_rsp();
        mode = 0;
    endtask

    task automatic test_backpressure();
        int lat;
        mode = 0; lat_cfg = 2;
        run_req(16'd500, 8'd9, lat);
        ReqValid = 1; ReqDividend = 16'hBEEF; ReqDivisor = 8'd3;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock); #1;
            checks++;
            if ({RspValid, ReqReady, RspStatus, RspQuotient, RspRemainder, DivDividend} !== {1'b1, 1'b0, 2'b00, 8'd55, 8'd5, 16'd500}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b st=%b q=%0d r=%0d dd=%0d expected v=1 rdy=0 st=00 q=55 r=5 dd=500",
                         k, RspValid, ReqReady, RspStatus, RspQuotient, RspRemainder, DivDividend);
            end
        end
        finish_rsp();
        checks++;
        if ({RspValid, ReqReady, Busy, DivDividend} !== {1'b0, 1'b1, 1'b0, 16'd500}) begin
            errors++;
            $display("FAIL release: got v=%b rdy=%b busy=%b dd=%h expected v=0 rdy=1 busy=0 dd=01f4", RspValid, ReqReady, Busy, DivDividend);
        end
        ReqValid = 0;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        mode = 1;
        ReqDividend = 16'd300; ReqDivisor = 8'd7; ReqValid = 1;
        @(posedge Clock); #1;
        ReqValid = 0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1;
        @(posedge Clock); #1;
        Reset = 0;
        checks++;
        if ({ReqReady, RspValid, DivStart, Busy, RspQuotient, RspRemainder, RspStatus, DivDividend, DivDivisor} !== {4'b1000, 42'd0}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", {ReqReady, RspValid, DivStart, Busy, RspQuotient, RspRemainder, RspStatus, DivDividend, DivDivisor}, {4'b1000, 42'd0});
        end
        mode = 0; lat_cfg = 3;
        run_req(16'd255, 8'd16, lat);
        checks++;
        if ({RspStatus, RspQuotient, RspRemainder} !== {2'b00, 8'h0F, 8'h0F} || lat !== 6) begin
            errors++;
            $display("FAIL after_reset_255_16: got st=%b q=%h r=%h lat=%0d expected st=00 q=0f r=0f lat=6", RspStatus, RspQuotient, RspRemainder, lat);
        end
        finish_rsp();
    endtask

    task automatic test_random();
        int lat, s0, exp_lat, exp_starts;
        int unsigned a, b;
        logic [1:0] exp_st;
        logic [7:0] exp_q, exp_r;
        mode = 0;
        for (int n = 0; n < 40; n++) begin
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            a = (n % 2 == 1 && b != 0) ? $urandom_range(0, b * 256 - 1) : $urandom_range(0, 65535);
            lat_cfg = $urandom_range(1, 12);
            if (b == 0) begin
                exp_st = 2'b01; exp_q = 8'hFF; exp_r = 8'h00; exp_lat = 1; exp_starts = 0;
            end else if (a / b > 255) begin
                exp_st = 2'b10; exp_q = 8'hFF; exp_r = 8'h00; exp_lat = 1; exp_starts = 0;
            end else begin
                exp_st = 2'b00; exp_q = 8'(a / b); exp_r = 8'(a % b); exp_lat = 3 + lat_cfg; exp_starts = 1;
            end
            s0 = start_cnt;
            run_req(16'(a), 8'(b), lat);
            checks++;
            if ({RspStatus, RspQuotient, RspRemainder} !== {exp_st, exp_q, exp_r} || lat !== exp_lat || start_cnt - s0 !== exp_starts) begin
                errors++;
                $display("FAIL rand%0d %0d/%0d: got st=%b q=%0d r=%0d lat=%0d starts=%0d expected st=%b q=%0d r=%0d lat=%0d starts=%0d",
                         n, a, b, RspStatus, RspQuotient, RspRemainder, lat, start_cnt - s0, exp_st, exp_q, exp_r, exp_lat, exp_starts);
            end
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            #1;
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_real_divide();
        test_div0();
        test_overflow_boundary();
        test_stubs();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
